nco_pipe: RTL and testbench

Parametrised, fully pipelined numerically controlled oscillator: phase accumulator, phase-offset adder, quantiser, quarter-wave sine/cosine lookup and sign stage. It generalises the existing fixed 32/16-bit NCO with configurable widths, a ready/valid configuration port, phase-continuous frequency hops, programmable phase offset, an output-valid strobe and a wrap strobe. It sits between the control/register interface and the mixer/DAC datapath.

---
 rtl/nco_pkg.sv | 37 +++
 rtl/nco_quarter_rom.sv | 43 ++++
 rtl/nco_pipe.sv | 203 ++++++++++++++++++++
 tb/tb_nco_pipe.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nco_pkg.sv
// nco_pkg: shared quadrant type, default widths and the quarter-wave table generator for nco_pipe.
// Dither helpers are only present when NCO_DITHER_EN is defined.
package nco_pkg;

  localparam int ACC_W_DEF   = 32;
  localparam int PHASE_W_DEF = 12;
  localparam int OUT_W_DEF   = 16;

  localparam real PI = 3.14159265358979323846;

  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } quadrant_e;

  // Entry i is sampled half an LSB into its bin, so it never reaches 0 or full negative scale.
  function automatic int quarter_sin(input int i, input int phase_w, input int out_w);
    real amp;
    real ang;
    amp = (2.0 ** (out_w - 1)) - 1.0;
    ang = 2.0 * PI * (real'(i) + 0.5) / (2.0 ** phase_w);
    return $rtoi(amp * $sin(ang) + 0.5);
  endfunction

`ifdef NCO_DITHER_EN
  localparam int          LFSR_W    = 16;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Fibonacci form of x^16 + x^14 + x^13 + x^11 + 1, shifting right.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction
`endif

endpackage

// File: rtl/nco_quarter_rom.sv
// nco_quarter_rom: quarter-wave sine table with two registered read ports,
// one at the address and one at its mirror (~addr).
module nco_quarter_rom
  import nco_pkg::*;
#(
  parameter int PHASE_W = PHASE_W_DEF,
  parameter int OUT_W   = OUT_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PHASE_W-3:0] addr,
  output logic [OUT_W-1:0]   data_fwd,
  output logic [OUT_W-1:0]   data_mir
);

  localparam int DEPTH = 1 << (PHASE_W - 2);

  logic [OUT_W-1:0]   table_s [DEPTH];
  logic [PHASE_W-3:0] addr_mir_s;
  logic [OUT_W-1:0]   data_fwd_r;
  logic [OUT_W-1:0]   data_mir_r;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    assign table_s[gi] = OUT_W'(quarter_sin(gi, PHASE_W, OUT_W));
  end

  assign addr_mir_s = ~addr;

  // Registered lookup of the forward and mirrored entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_fwd_r <= {OUT_W{1'b0}};
      data_mir_r <= {OUT_W{1'b0}};
    end else begin
      data_fwd_r <= table_s[addr];
      data_mir_r <= table_s[addr_mir_s];
    end
  end

  assign data_fwd = data_fwd_r;
  assign data_mir = data_mir_r;

endmodule

// File: rtl/nco_pipe.sv
// nco_pipe: pipelined NCO (accumulator, phase offset, quantiser, quarter-wave ROM, sign stage)
// with a one-deep config port. Define NCO_DITHER_EN to add LFSR dither ahead of truncation.
module nco_pipe
  import nco_pkg::*;
#(
  parameter int ACC_W   = ACC_W_DEF,
  parameter int PHASE_W = PHASE_W_DEF,
  parameter int OUT_W   = OUT_W_DEF
) (
  input  logic                    clk_top,
  input  logic                    rst_top,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [ACC_W-1:0]        cfg_freq,
  input  logic [ACC_W-1:0]        cfg_phase,
  input  logic                    cfg_sync,
  input  logic                    NCO_enable,
  output logic signed [OUT_W-1:0] NCO_sin_out,
  output logic signed [OUT_W-1:0] NCO_cos_out,
  output logic                    NCO_valid_out,
  output logic                    NCO_wrap_out
);

  localparam int FRAC_W = ACC_W - PHASE_W;

  logic [ACC_W-1:0]   acc_r, freq_r, phase_r, pend_freq_r, pend_phase_r;
  logic               pend_sync_r, cfg_ready_r;
  logic [ACC_W:0]     sum_s;
  logic               carry_s, pending_s, accept_s, sync_apply_s, step_s, apply_s;
  logic [ACC_W-1:0]   p1_r, p1_q_s;
  logic               v1_r, w1_r, v2_r, w2_r, v3_r, w3_r;
  logic [PHASE_W-1:0] q2_r;
  quadrant_e          quad3_r;
  logic [OUT_W-1:0]   rom_fwd_s, rom_mir_s;
  logic signed [OUT_W-1:0] fwd_s, mir_s, sin_s, cos_s, sin_r, cos_r;
  logic               valid_r, wrap_r;

  assign sum_s        = {1'b0, acc_r} + {1'b0, freq_r};
  assign carry_s      = sum_s[ACC_W];
  assign pending_s    = ~cfg_ready_r;
  assign accept_s     = cfg_valid & cfg_ready_r;
  // A pending sync clears the accumulator and suppresses this edge's sample.
  assign sync_apply_s = pending_s & pend_sync_r;
  assign step_s       = NCO_enable & ~sync_apply_s;
  assign apply_s      = sync_apply_s | (pending_s & (~NCO_enable | carry_s));

  // Accumulator, active frequency/phase words and the pending config slot.
  always_ff @(posedge clk_top or negedge rst_top) begin
    if (!rst_top) begin
      acc_r        <= {ACC_W{1'b0}};
      freq_r       <= {ACC_W{1'b0}};
      phase_r      <= {ACC_W{1'b0}};
      pend_freq_r  <= {ACC_W{1'b0}};
      pend_phase_r <= {ACC_W{1'b0}};
      pend_sync_r  <= 1'b0;
      cfg_ready_r  <= 1'b1;
    end else begin
      if (sync_apply_s) begin
        acc_r <= {ACC_W{1'b0}};
      end else if (step_s) begin
        acc_r <= sum_s[ACC_W-1:0];
      end
      if (apply_s) begin
        freq_r  <= pend_freq_r;
        phase_r <= pend_phase_r;
      end
      if (accept_s) begin
        pend_freq_r  <= cfg_freq;
        pend_phase_r <= cfg_phase;
        pend_sync_r  <= cfg_sync;
        cfg_ready_r  <= 1'b0;
      end else if (apply_s) begin
        cfg_ready_r <= 1'b1;
      end
    end
  end

  // Stage 1: offset phase from the pre-add accumulator, plus valid and carry.
  always_ff @(posedge clk_top or negedge rst_top) begin
    if (!rst_top) begin
      p1_r <= {ACC_W{1'b0}};
      v1_r <= 1'b0;
      w1_r <= 1'b0;
    end else begin
      p1_r <= acc_r + phase_r;
      v1_r <= step_s;
      w1_r <= step_s & carry_s;
    end
  end

`ifdef NCO_DITHER_EN
  localparam int DITH_W = (FRAC_W < LFSR_W) ? FRAC_W : LFSR_W;

  logic [LFSR_W-1:0] lfsr_r;
  logic [ACC_W-1:0]  dith_s;

  // Dither source; steps only when a valid sample is quantised.
  always_ff @(posedge clk_top or negedge rst_top) begin
    if (!rst_top) begin
      lfsr_r <= LFSR_SEED;
    end else if (v1_r) begin
      lfsr_r <= lfsr_next(lfsr_r);
    end
  end

  assign dith_s = ACC_W'(lfsr_r[LFSR_W-1 -: DITH_W]) << (FRAC_W - DITH_W);
  assign p1_q_s = p1_r + dith_s;
`else
  assign p1_q_s = p1_r;
`endif

  // Stage 2: truncate to the quantised phase.
  always_ff @(posedge clk_top or negedge rst_top) begin
    if (!rst_top) begin
      q2_r <= {PHASE_W{1'b0}};
      v2_r <= 1'b0;
      w2_r <= 1'b0;
    end else begin
      q2_r <= PHASE_W'(p1_q_s >> FRAC_W);
      v2_r <= v1_r;
      w2_r <= w1_r;
    end
  end

  nco_quarter_rom #(
    .PHASE_W (PHASE_W),
    .OUT_W   (OUT_W)
  ) u_rom (
    .clk      (clk_top),
    .rst_n    (rst_top),
    .addr     (q2_r[PHASE_W-3:0]),
    .data_fwd (rom_fwd_s),
    .data_mir (rom_mir_s)
  );

  // Stage 3: quadrant, valid and wrap travel alongside the ROM read.
  always_ff @(posedge clk_top or negedge rst_top) begin
    if (!rst_top) begin
      quad3_r <= Q0;
      v3_r    <= 1'b0;
      w3_r    <= 1'b0;
    end else begin
      quad3_r <= quadrant_e'(q2_r[PHASE_W-1 -: 2]);
      v3_r    <= v2_r;
      w3_r    <= w2_r;
    end
  end

  assign fwd_s = signed'(rom_fwd_s);
  assign mir_s = signed'(rom_mir_s);

  // Quadrant folding; table entries stay below full scale so negation cannot overflow.
  always_comb begin
    sin_s = fwd_s;
    cos_s = mir_s;
    case (quad3_r)
      Q0: begin
        sin_s = fwd_s;
        cos_s = mir_s;
      end
      Q1: begin
        sin_s = mir_s;
        cos_s = -fwd_s;
      end
      Q2: begin
        sin_s = -fwd_s;
        cos_s = -mir_s;
      end
      Q3: begin
        sin_s = -mir_s;
        cos_s = fwd_s;
      end
      default: begin
        sin_s = fwd_s;
        cos_s = mir_s;
      end
    endcase
  end

  // Stage 4: output registers hold their value across bubbles.
  always_ff @(posedge clk_top or negedge rst_top) begin
    if (!rst_top) begin
      sin_r   <= {OUT_W{1'b0}};
      cos_r   <= {OUT_W{1'b0}};
      valid_r <= 1'b0;
      wrap_r  <= 1'b0;
    end else begin
      if (v3_r) begin
        sin_r <= sin_s;
        cos_r <= cos_s;
      end
      valid_r <= v3_r;
      wrap_r  <= v3_r & w3_r;
    end
  end

  assign cfg_ready     = cfg_ready_r;
  assign NCO_sin_out   = sin_r;
  assign NCO_cos_out   = cos_r;
  assign NCO_valid_out = valid_r;
  assign NCO_wrap_out  = wrap_r;

endmodule

// File: tb/tb_nco_pipe.sv
// tb_nco_pipe: directed tables, corner sequences and random stimulus for nco_pipe,
// checked every cycle against a sample-level reference model.
module tb_nco_pipe;

  localparam longint unsigned MOD    = 64'h1_0000_0000;
  localparam real             AMP    = 32767.0;
  localparam real             TWO_PI = 6.283185307179586;

  logic               clk_top = 1'b0;
  logic               rst_top = 1'b0;
  logic               cfg_valid = 1'b0;
  logic               cfg_sync = 1'b0;
  logic               NCO_enable = 1'b0;
  logic [31:0]        cfg_freq = 32'd0;
  logic [31:0]        cfg_phase = 32'd0;
  logic               cfg_ready, NCO_valid_out, NCO_wrap_out;
  logic signed [15:0] NCO_sin_out, NCO_cos_out;

  int n_tests = 0;
  int n_fail  = 0;

  nco_pipe dut (
    .clk_top       (clk_top),
    .rst_top       (rst_top),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_freq      (cfg_freq),
    .cfg_phase     (cfg_phase),
    .cfg_sync      (cfg_sync),
    .NCO_enable    (NCO_enable),
    .NCO_sin_out   (NCO_sin_out),
    .NCO_cos_out   (NCO_cos_out),
    .NCO_valid_out (NCO_valid_out),
    .NCO_wrap_out  (NCO_wrap_out)
  );

  always #5 clk_top = ~clk_top;

  // Reference model: ideal phase arithmetic and a real-valued sine per sample.
  typedef struct {bit v; bit w; int s; int c;} samp_t;
  longint unsigned m_acc, m_freq, m_phase, m_pf, m_pp;
  bit              m_ps, m_pend, m_v, m_w;
  int              m_sin_h, m_cos_h;
  samp_t           m_pipe[$];

  typedef struct {logic [31:0] phase; int e_sin; int e_cos;} vec_t;
  vec_t vecs[7];

  function automatic int rnd(real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    else return -$rtoi(-x + 0.5);
  endfunction

  function automatic real bin_angle(longint unsigned p);
    return TWO_PI * (real'(p >> 20) + 0.5) / 4096.0;
  endfunction

  task automatic check(string name, logic signed [63:0] act, logic signed [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    samp_t z;
    z = '{0, 0, 0, 0};
    m_acc = 0; m_freq = 0; m_phase = 0; m_pf = 0; m_pp = 0;
    m_ps = 0; m_pend = 0; m_v = 0; m_w = 0; m_sin_h = 0; m_cos_h = 0;
    m_pipe.delete();
    repeat (3) m_pipe.push_back(z);
  endtask

  task automatic model_step();
    samp_t e;
    bit was_pend, apply;
    longint unsigned p;
    e = '{0, 0, 0, 0};
    was_pend = m_pend;
    apply = 0;
    if (was_pend && m_ps) begin
      m_acc = 0;
      apply = 1;
    end else if (NCO_enable) begin
      p   = (m_acc + m_phase) % MOD;
      e.v = 1;
      e.w = ((m_acc + m_freq) >= MOD);
      e.s = rnd(AMP * $sin(bin_angle(p)));
      e.c = rnd(AMP * $cos(bin_angle(p)));
      m_acc = (m_acc + m_freq) % MOD;
      apply = was_pend && e.w;
    end else begin
      apply = was_pend;
    end
    if (apply) begin
      m_freq = m_pf; m_phase = m_pp; m_pend = 0;
    end
    if (cfg_valid && !was_pend) begin
      m_pf = cfg_freq; m_pp = cfg_phase; m_ps = cfg_sync; m_pend = 1;
    end
    m_pipe.push_back(e);
    e = m_pipe.pop_front();
    m_v = e.v;
    m_w = e.w;
    if (e.v) begin
      m_sin_h = e.s; m_cos_h = e.c;
    end
  endtask

  task automatic check_model();
    check("sin", NCO_sin_out, m_sin_h);
    check("cos", NCO_cos_out, m_cos_h);
    check("valid", NCO_valid_out, m_v);
    check("wrap", NCO_wrap_out, m_w);
    check("cfg_ready", cfg_ready, !m_pend);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk_top);
    #1;
    check_model();
  endtask

  task automatic send_cfg(logic [31:0] f, logic [31:0] p, logic s, logic en);
    cfg_valid = 1'b1; cfg_freq = f; cfg_phase = p; cfg_sync = s; NCO_enable = en;
    tick();
    cfg_valid = 1'b0; cfg_sync = 1'b0;
  endtask

  task automatic sync_cfg(logic [31:0] f, logic [31:0] p);
    send_cfg(f, p, 1'b1, 1'b0);
    tick();
  endtask

  task automatic drain();
    NCO_enable = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    int seq_sin[4];
    int seq_cos[4];
    int seq_wrap[4];
    int vpat[8];
    int en_pat[8];

    vecs[0] = '{32'h0000_0000, 25, 32767};
    vecs[1] = '{32'h4000_0000, 32767, -25};
    vecs[2] = '{32'h8000_0000, -25, -32767};
    vecs[3] = '{32'hC000_0000, -32767, 25};
    vecs[4] = '{32'h0010_0000, 75, 32767};
    vecs[5] = '{32'h7FF0_0000, 25, -32767};
    vecs[6] = '{32'hFFF0_0000, -25, 32767};
    seq_sin  = '{25, 32767, -25, -32767};
    seq_cos  = '{32767, -25, -32767, 25};
    seq_wrap = '{0, 0, 0, 1};
    en_pat   = '{1, 0, 1, 1, 0, 0, 0, 0};
    vpat     = '{0, 0, 0, 1, 0, 1, 1, 0};

    model_reset();
    repeat (2) @(posedge clk_top);
    #1;
    check("rst_sin", NCO_sin_out, 0);
    check("rst_cos", NCO_cos_out, 0);
    check("rst_valid", NCO_valid_out, 0);
    check("rst_wrap", NCO_wrap_out, 0);
    check("rst_ready", cfg_ready, 1);
    @(negedge clk_top);
    rst_top = 1'b1;

    // freq = 0, phase = 0: constant first-bin sample every cycle from the 4th edge.
    NCO_enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i >= 3) begin
        check("dc_valid", NCO_valid_out, 1);
        check("dc_sin", NCO_sin_out, 25);
        check("dc_cos", NCO_cos_out, 32767);
      end
    end
    drain();

    // Phase-offset table.
    for (int k = 0; k < 7; k++) begin
      sync_cfg(32'd0, vecs[k].phase);
      NCO_enable = 1'b1;
      repeat (4) tick();
      check("tbl_valid", NCO_valid_out, 1);
      check("tbl_sin", NCO_sin_out, vecs[k].e_sin);
      check("tbl_cos", NCO_cos_out, vecs[k].e_cos);
      drain();
    end

    // Quarter-turn stepping with wrap on the 4th sample.
    sync_cfg(32'h4000_0000, 32'd0);
    NCO_enable = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 0) tick();
      else begin
        NCO_enable = 1'b0;
        tick();
      end
      check("q_sin", NCO_sin_out, seq_sin[i]);
      check("q_cos", NCO_cos_out, seq_cos[i]);
      check("q_wrap", NCO_wrap_out, seq_wrap[i]);
    end

    // Non-sync phase hop mid-cycle waits for the wrap.
    NCO_enable = 1'b1;
    tick();
    send_cfg(32'h4000_0000, 32'h4000_0000, 1'b0, 1'b1);
    check("hop_ready_b", cfg_ready, 0);
    tick();
    check("hop_ready_c", cfg_ready, 0);
    tick();
    check("hop_ready_d", cfg_ready, 1);
    repeat (5) tick();
    drain();

    // Enable gaps: valid follows enable three cycles later, outputs hold.
    for (int i = 0; i < 8; i++) begin
      NCO_enable = en_pat[i][0];
      tick();
      check("gap_valid", NCO_valid_out, vpat[i]);
    end

    // Request while busy is ignored.
    sync_cfg(32'h0100_0000, 32'd0);
    NCO_enable = 1'b1;
    tick();
    send_cfg(32'h4000_0000, 32'd0, 1'b0, 1'b1);
    cfg_valid = 1'b1; cfg_freq = 32'h8000_0000; cfg_phase = 32'h1234_5678; cfg_sync = 1'b1;
    tick();
    check("busy_ready", cfg_ready, 0);
    cfg_valid = 1'b0; cfg_sync = 1'b0;
    NCO_enable = 1'b0;
    tick();
    check("busy_apply", cfg_ready, 1);
    NCO_enable = 1'b1;
    repeat (6) tick();
    drain();

    // Asynchronous reset with an update pending.
    sync_cfg(32'h0100_0000, 32'd0);
    NCO_enable = 1'b1;
    repeat (4) tick();
    send_cfg(32'h2000_0000, 32'd0, 1'b0, 1'b1);
    #2;
    rst_top = 1'b0;
    #1;
    check("arst_sin", NCO_sin_out, 0);
    check("arst_cos", NCO_cos_out, 0);
    check("arst_valid", NCO_valid_out, 0);
    check("arst_wrap", NCO_wrap_out, 0);
    check("arst_ready", cfg_ready, 1);
    model_reset();
    NCO_enable = 1'b0;
    repeat (2) @(negedge clk_top);
    rst_top = 1'b1;
    tick();

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      NCO_enable = ($urandom_range(0, 9) < 8);
      cfg_valid  = ($urandom_range(0, 9) < 2);
      cfg_sync   = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 2))
        0:       cfg_freq = $urandom;
        1:       cfg_freq = 32'($urandom_range(0, 255)) << 24;
        default: cfg_freq = $urandom >> 8;
      endcase
      cfg_phase = $urandom;
      tick();
    end
    cfg_valid = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
